reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; ports and meanings as follows.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 CLR  in  1  synchronous active-high reset.
REQ-004 FLUSH  in  1  pipeline flush; clears all pending state.
REQ-005 AG_v  in  1  AG stage holds a valid instruction.
REQ-006 AG_issue  in  1  AG requests advance this cycle.
REQ-007 AG_sr1_sel/AG_sr2_sel/AG_sr3_sel  in  3 each  GPR source selects.
REQ-008 AG_sr1_type/AG_sr2_type/AG_sr3_type  in  2 each  GPR source widths (00 byte, 01 word, 10 dword).
REQ-009 AG_sr1_v/AG_sr2_v/AG_sr3_v  in  1 each  GPR source used.
REQ-010 AG_segment_sel/AG_ssegr_sel, AG_segment_v/AG_ssegr_v  in  3/1 each  segment sources.
REQ-011 AG_smmx1_sel/AG_smmx2_sel, AG_smmx1_v/AG_smmx2_v  in  3/1 each  MMX sources.
REQ-012 AG_dr1_sel/AG_dr2_sel, AG_dr1_type/AG_dr2_type, AG_dr1_ld/AG_dr2_ld  in  3/2/1 each  GPR destinations of the issuing instruction.
REQ-013 AG_dsegr_sel/AG_dmmx_sel, AG_dsegr_ld/AG_dmmx_ld  in  3/1 each  segment and MMX destinations.
REQ-014 WB_v, WB_dr1_sel, WB_dr2_sel, WB_dsegr_sel, WB_dmmx_sel, WB_dr1_type, WB_dr2_type, WB_dr1_ld, WB_dr2_ld, WB_dsegr_ld, WB_dmmx_ld  in  1/3/3/3/3/2/2/1/1/1/1  retiring writes.
REQ-015 DFU_dep_stall  out  1  hold AG; combinational from state and AG inputs.
REQ-016 SB_issue_ack  out  1  issue accepted this cycle.

Function
REQ-017 SHALL keep a 2-bit pending-write counter per register: 8 GPR, 8 segment, 8 MMX (24 counters).
REQ-018 GPR index SHALL be sel[1:0] when type==00 (AH..BH alias AL..BL), else sel; same mapping for sources, AG destinations and WB destinations.
REQ-019 Hazard SHALL be asserted when any source with its _v set maps to a counter != 0.
REQ-020 Saturation SHALL be asserted when any AG destination with _ld set maps to a counter == 3.
REQ-021 DFU_dep_stall SHALL equal AG_v & (hazard | saturation).
REQ-022 SB_issue_ack SHALL equal AG_v & AG_issue & ~DFU_dep_stall & ~FLUSH.
REQ-023 On SB_issue_ack, each AG destination with _ld set SHALL increment its counter; dr1 and dr2 mapping to the same GPR SHALL increment it once.
REQ-024 When WB_v is high, each WB destination with _ld set SHALL decrement its counter; a decrement of a zero counter SHALL leave it at 0.
REQ-025 Increment and decrement of the same counter in one cycle SHALL leave it unchanged.
REQ-026 Hazard is evaluated on pre-update state; a WB retiring in the same cycle does not clear a stall until the next cycle.
REQ-027 FLUSH SHALL zero all counters next edge, overriding issue and retire in that cycle.

Reset
REQ-028 CLR SHALL zero all counters on the next rising edge, overriding FLUSH, issue and retire; after reset DFU_dep_stall=0 and SB_issue_ack follows REQ-022.
REQ-029 CLR asserted mid-stall SHALL release the stall on the cycle after the edge.

Configuration
REQ-030 With SCOREBOARD_STATS_EN defined, SHALL add output SB_stall_cnt (16 bits) counting cycles with DFU_dep_stall=1, saturating at 16'hFFFF, cleared by CLR only; without it, the port and counter SHALL be absent.

Structure
REQ-031 Shared package sb_pkg SHALL hold the counter width, max count (3), GPR type encodings and the register-class enum (GPR, SEG, MMX).
REQ-032 One sub-module, sb_counter_bank (8 counters, 2 inc ports, 1 dec port, flush), SHALL be instantiated per class.

Verification
REQ-033 Issue dr1=EAX(sel0,dword); next cycle AG reads sr1=0 -> DFU_dep_stall=1 until cycle after WB_dr1_sel=0,ld=1.
REQ-034 Issue dr1 sel4 type byte (AH); AG reads sr1 sel0 type dword -> stall=1.
REQ-035 Three issues to MMX3 with no retire; fourth issuing to MMX3 -> stall=1 (saturation), ack=0.
REQ-036 Counter GPR2=1; same cycle issue to GPR2 and WB retire GPR2 -> counter stays 1.
REQ-037 Pending writes on GPR1, SEG2, MMX5; FLUSH=1 one cycle -> all counters 0, stall=0 next cycle.
REQ-038 CLR with FLUSH and issue asserted -> counters 0; with SCOREBOARD_STATS_EN, 5 stall cycles -> SB_stall_cnt=5.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types and constants for the register scoreboard.
// Counter width, saturation limit, GPR width codes and register classes.
package sb_pkg;

    localparam int NREG  = 8;
    localparam int CNT_W = 2;

    localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;
    localparam logic [CNT_W-1:0] CNT_ONE = 2'd1;

    localparam logic [1:0] TYPE_BYTE  = 2'b00;
    localparam logic [1:0] TYPE_WORD  = 2'b01;
    localparam logic [1:0] TYPE_DWORD = 2'b10;

    typedef enum logic [1:0] {
        CLS_GPR,
        CLS_SEG,
        CLS_MMX
    } reg_class_e;

    typedef logic [NREG-1:0][CNT_W-1:0] cnt_vec_t;

    // Byte selects 4..7 (AH..BH) share the counter of AL..BL.
    function automatic logic [2:0] gpr_idx(input logic [2:0] sel,
                                           input logic [1:0] typ);
        return (typ == TYPE_BYTE) ? {1'b0, sel[1:0]} : sel;
    endfunction

    function automatic logic [NREG-1:0] onehot(input logic v,
                                               input logic [2:0] idx);
        logic [NREG-1:0] r;
        r = '0;
        if (v) r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Eight saturating 2-bit pending-write counters for one register class.
// Two increment ports (second used only by GPRs), one decrement mask, clear.
module sb_counter_bank
    import sb_pkg::*;
#(
    parameter reg_class_e CLS = CLS_GPR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inc0_v,
    input  logic [2:0]      inc0_idx,
    input  logic            inc1_v,
    input  logic [2:0]      inc1_idx,
    input  logic [NREG-1:0] dec_mask,
    output cnt_vec_t        cnt
);

    cnt_vec_t        cnt_q;
    cnt_vec_t        cnt_d;
    logic [NREG-1:0] inc_mask;

    // A duplicated destination collapses into a single increment.
    always_comb begin
        inc_mask = onehot(inc0_v, inc0_idx)
                 | onehot(inc1_v && (CLS == CLS_GPR), inc1_idx);
        cnt_d = cnt_q;
        for (int i = 0; i < NREG; i++) begin
            if (rst || flush) begin
                cnt_d[i] = '0;
            end else if (inc_mask[i] && !dec_mask[i]) begin
                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (dec_mask[i] && !inc_mask[i]) begin
                if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register dependency scoreboard: stalls AG on pending writes or full counters.
// Define SCOREBOARD_STATS_EN to add the SB_stall_cnt stall-cycle counter.
module reg_scoreboard
    import sb_pkg::*;
(
    input  logic       CLK,
    input  logic       CLR,
    input  logic       FLUSH,
    input  logic       AG_v,
    input  logic       AG_issue,
    input  logic [2:0] AG_sr1_sel,
    input  logic [2:0] AG_sr2_sel,
    input  logic [2:0] AG_sr3_sel,
    input  logic [1:0] AG_sr1_type,
    input  logic [1:0] AG_sr2_type,
    input  logic [1:0] AG_sr3_type,
    input  logic       AG_sr1_v,
    input  logic       AG_sr2_v,
    input  logic       AG_sr3_v,
    input  logic [2:0] AG_segment_sel,
    input  logic [2:0] AG_ssegr_sel,
    input  logic       AG_segment_v,
    input  logic       AG_ssegr_v,
    input  logic [2:0] AG_smmx1_sel,
    input  logic [2:0] AG_smmx2_sel,
    input  logic       AG_smmx1_v,
    input  logic       AG_smmx2_v,
    input  logic [2:0] AG_dr1_sel,
    input  logic [2:0] AG_dr2_sel,
    input  logic [1:0] AG_dr1_type,
    input  logic [1:0] AG_dr2_type,
    input  logic       AG_dr1_ld,
    input  logic       AG_dr2_ld,
    input  logic [2:0] AG_dsegr_sel,
    input  logic [2:0] AG_dmmx_sel,
    input  logic       AG_dsegr_ld,
    input  logic       AG_dmmx_ld,
    input  logic       WB_v,
    input  logic [2:0] WB_dr1_sel,
    input  logic [2:0] WB_dr2_sel,
    input  logic [2:0] WB_dsegr_sel,
    input  logic [2:0] WB_dmmx_sel,
    input  logic [1:0] WB_dr1_type,
    input  logic [1:0] WB_dr2_type,
    input  logic       WB_dr1_ld,
    input  logic       WB_dr2_ld,
    input  logic       WB_dsegr_ld,
    input  logic       WB_dmmx_ld,
    output logic       DFU_dep_stall,
    output logic       SB_issue_ack
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0] SB_stall_cnt
`endif
);

    cnt_vec_t   gpr_cnt;
    cnt_vec_t   seg_cnt;
    cnt_vec_t   mmx_cnt;
    logic [2:0] dr1_idx;
    logic [2:0] dr2_idx;
    logic       hazard;
    logic       satur;

    assign dr1_idx = gpr_idx(AG_dr1_sel, AG_dr1_type);
    assign dr2_idx = gpr_idx(AG_dr2_sel, AG_dr2_type);

    always_comb begin
        hazard = 1'b0;
        if (AG_sr1_v && gpr_cnt[gpr_idx(AG_sr1_sel, AG_sr1_type)] != '0)
            hazard = 1'b1;
        if (AG_sr2_v && gpr_cnt[gpr_idx(AG_sr2_sel, AG_sr2_type)] != '0)
            hazard = 1'b1;
        if (AG_sr3_v && gpr_cnt[gpr_idx(AG_sr3_sel, AG_sr3_type)] != '0)
            hazard = 1'b1;
        if (AG_segment_v && seg_cnt[AG_segment_sel] != '0) hazard = 1'b1;
        if (AG_ssegr_v && seg_cnt[AG_ssegr_sel] != '0)     hazard = 1'b1;
        if (AG_smmx1_v && mmx_cnt[AG_smmx1_sel] != '0)     hazard = 1'b1;
        if (AG_smmx2_v && mmx_cnt[AG_smmx2_sel] != '0)     hazard = 1'b1;
    end

    always_comb begin
        satur = 1'b0;
        if (AG_dr1_ld && gpr_cnt[dr1_idx] == CNT_MAX)        satur = 1'b1;
        if (AG_dr2_ld && gpr_cnt[dr2_idx] == CNT_MAX)        satur = 1'b1;
        if (AG_dsegr_ld && seg_cnt[AG_dsegr_sel] == CNT_MAX) satur = 1'b1;
        if (AG_dmmx_ld && mmx_cnt[AG_dmmx_sel] == CNT_MAX)   satur = 1'b1;
    end

    assign DFU_dep_stall = AG_v & (hazard | satur);
    assign SB_issue_ack  = AG_v & AG_issue & ~DFU_dep_stall & ~FLUSH;

    sb_counter_bank #(.CLS(CLS_GPR)) u_gpr (
        .clk      (CLK),
        .rst      (CLR),
        .flush    (FLUSH),
        .inc0_v   (SB_issue_ack & AG_dr1_ld),
        .inc0_idx (dr1_idx),
        .inc1_v   (SB_issue_ack & AG_dr2_ld),
        .inc1_idx (dr2_idx),
        .dec_mask (WB_v ? (onehot(WB_dr1_ld, gpr_idx(WB_dr1_sel, WB_dr1_type))
                         | onehot(WB_dr2_ld, gpr_idx(WB_dr2_sel, WB_dr2_type)))
                        : '0),
        .cnt      (gpr_cnt)
    );

    sb_counter_bank #(.CLS(CLS_SEG)) u_seg (
        .clk      (CLK),
        .rst      (CLR),
        .flush    (FLUSH),
        .inc0_v   (SB_issue_ack & AG_dsegr_ld),
        .inc0_idx (AG_dsegr_sel),
        .inc1_v   (1'b0),
        .inc1_idx (3'd0),
        .dec_mask (onehot(WB_v & WB_dsegr_ld, WB_dsegr_sel)),
        .cnt      (seg_cnt)
    );

    sb_counter_bank #(.CLS(CLS_MMX)) u_mmx (
        .clk      (CLK),
        .rst      (CLR),
        .flush    (FLUSH),
        .inc0_v   (SB_issue_ack & AG_dmmx_ld),
        .inc0_idx (AG_dmmx_sel),
        .inc1_v   (1'b0),
        .inc1_idx (3'd0),
        .dec_mask (onehot(WB_v & WB_dmmx_ld, WB_dmmx_sel)),
        .cnt      (mmx_cnt)
    );

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // FLUSH deliberately leaves the statistic untouched.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (CLR)
            stall_cnt_d = '0;
        else if (DFU_dep_stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        stall_cnt_q <= stall_cnt_d;
    end

    assign SB_stall_cnt = stall_cnt_q;
`endif

endmodule
